// File: rtl/binary_to_bcd_conv.sv
// binary_to_bcd_conv: sequential double-dabble binary-to-BCD converter with valid/ready on both sides.
// Optional macro BIN2BCD_2BIT_EN: two correct-then-shift steps per cycle (WIDTH must be even).
`default_nettype none

module binary_to_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + WIDTH;
    localparam int CNT_W  = $clog2(WIDTH + 1);
`ifdef BIN2BCD_2BIT_EN
    localparam int STEPS  = 2;
`else
    localparam int STEPS  = 1;
`endif
    localparam int CNT_LOAD = WIDTH / STEPS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [WORK_W-1:0]   step_w;

    // Add-3 on every BCD digit >= 5 (4-bit wrap is safe: max 9+3 = 12), then shift left.
    function automatic logic [WORK_W-1:0] dabble(input logic [WORK_W-1:0] v);
        logic [WORK_W-1:0] t;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[WIDTH + 4*d +: 4] >= 4'd5) begin
                t[WIDTH + 4*d +: 4] = t[WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        return {t[WORK_W-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        step_w  = work_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = {{BCD_W{1'b0}}, in_data};
                    cnt_d   = CNT_W'(CNT_LOAD);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                step_w = dabble(work_q);
`ifdef BIN2BCD_2BIT_EN
                step_w = dabble(step_w);
`endif
                work_d = step_w;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = step_w[WORK_W-1 -: BCD_W];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign out_bcd   = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_conv.sv
// tb_binary_to_bcd_conv: directed table vectors plus hand-written handshake/reset sequences.
`default_nettype none

module tb_binary_to_bcd_conv;

`ifdef BIN2BCD_2BIT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    binary_to_bcd_conv #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  din;
        int          hold;
        logic [11:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Called and returns at a negedge; result and latency in cycles from accept edge.
    task automatic do_conv(input logic [7:0] d, input int hold,
                           output logic [11:0] res, output int lat);
        int n;
        int acc;
        logic busy_ok;
        logic stable_ok;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 50), 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        busy_ok  = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(n < 50), 32'd1);
        res = out_bcd;
        lat = cyc - acc;
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || out_bcd !== res || in_ready) stable_ok = 1'b0;
        end
        check("in_ready_low_busy", 32'(busy_ok), 32'd1);
        check("hold_stable", 32'(stable_ok), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_handoff", {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    vec_t        tab[10];
    logic [11:0] res;
    int          lat;
    logic [11:0] seq_exp[4];
    logic [7:0]  seq_in[4];
    logic [11:0] got[4];
    int          acc_c[4];

    initial begin
        tab[0] = '{8'd0,   0,  12'h000};
        tab[1] = '{8'd255, 0,  12'h255};
        tab[2] = '{8'd99,  1,  12'h099};
        tab[3] = '{8'd100, 0,  12'h100};
        tab[4] = '{8'd9,   2,  12'h009};
        tab[5] = '{8'd173, 20, 12'h173};
        tab[6] = '{8'd1,   0,  12'h001};
        tab[7] = '{8'd128, 3,  12'h128};
        tab[8] = '{8'd50,  0,  12'h050};
        tab[9] = '{8'd199, 1,  12'h199};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'hA5; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {18'd0, out_valid, in_ready, out_bcd}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);
        // in_valid low: garbage in_data must be ignored
        repeat (3) @(negedge clk);
        check("idle_ignores_data", {30'd0, out_valid, in_ready}, 32'b01);

        foreach (tab[i]) begin
            do_conv(tab[i].din, tab[i].hold, res, lat);
            check($sformatf("vec%0d_bcd", i), 32'(res), 32'(tab[i].exp));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
        end

        // Back-to-back with out_ready and in_valid held high through DONE
        seq_in  = '{8'd255, 8'd99, 8'd100, 8'd9};
        seq_exp = '{12'h255, 12'h099, 12'h100, 12'h009};
        begin
            int idx = 0;
            int ng = 0;
            logic done_block_ok = 1'b1;
            in_valid = 1'b1; in_data = seq_in[0]; out_ready = 1'b1;
            for (int c = 0; c < 100 && ng < 4; c++) begin
                if (out_valid) begin
                    got[ng] = out_bcd;
                    ng++;
                    if (in_ready) done_block_ok = 1'b0;
                end
                if (idx == 4) in_valid = 1'b0;
                else if (in_ready) begin
                    in_data = seq_in[idx];
                    acc_c[idx] = cyc + 1;
                    idx++;
                end
                @(negedge clk);
            end
            in_valid = 1'b0; out_ready = 1'b0;
            check("b2b_count", 32'(ng), 32'd4);
            check("done_no_accept", 32'(done_block_ok), 32'd1);
            for (int i = 0; i < 4; i++) check($sformatf("b2b%0d_bcd", i), 32'(got[i]), 32'(seq_exp[i]));
            for (int i = 0; i < 3; i++) check($sformatf("b2b%0d_gap", i), 32'(acc_c[i+1] - acc_c[i]), 32'(LAT + 2));
            @(negedge clk);
        end

        // Reset mid-conversion discards the operand and clears out_bcd
        in_data = 8'd200; in_valid = 1'b1;
        while (!in_ready) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_shift", {18'd0, out_valid, in_ready, out_bcd}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        begin
            logic spurious = 1'b0;
            for (int i = 0; i < LAT + 3; i++) begin
                if (out_valid) spurious = 1'b1;
                @(negedge clk);
            end
            check("no_output_after_rst", 32'(spurious), 32'd0);
        end
        do_conv(8'd42, 0, res, lat);
        check("post_rst_42", 32'(res), 32'h042);

        // Reset while in DONE with out_ready low
        do_conv(8'd77, 0, res, lat);
        in_data = 8'd88; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid) @(negedge clk);
        check("pre_rst_done_88", 32'(out_bcd), 32'h088);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_done", {18'd0, out_valid, 1'b0, out_bcd}, 32'd0);

        // Exhaustive sweep with random gaps on both sides
        for (int v = 0; v < 256; v++) begin
            logic dig_ok;
            repeat ($urandom_range(0, 3)) begin
                in_data = 8'($urandom);
                @(negedge clk);
            end
            do_conv(8'(v), $urandom_range(0, 3), res, lat);
            dig_ok = (res[3:0] <= 4'd9) && (res[7:4] <= 4'd9) && (res[11:8] <= 4'd9);
            check($sformatf("sweep%0d_bcd", v), 32'(res), 32'(model(v)));
            check($sformatf("sweep%0d_digits", v), 32'(dig_ok), 32'd1);
            check($sformatf("sweep%0d_lat", v), 32'(lat), 32'(LAT));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/binary_to_bcd_conv.md
# binary_to_bcd_conv

Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm. It takes a WIDTH-bit unsigned binary value and returns DIGITS packed BCD digits. It is the inverse of the team's combinational BCD-to-binary converter and sits on the display/readout path, where binary counters and ALU results must be shown as decimal. Both sides use valid/ready handshakes, so the block can sit between pipelined producers and consumers.

## Interface
Parameters:
- WIDTH, 8, binary input width; must be ≥ 2.
- DIGITS, 3, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept input; high only in IDLE and never while rst is high.
- in_data  input  WIDTH  unsigned binary operand.
- out_valid  output  1  out_bcd holds a completed result.
- out_ready  input  1  consumer accepts the result.
- out_bcd  output  4*DIGITS  packed BCD: [3:0] ones, [7:4] tens, and so on upward.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load working register {bcd = 0, bin = in_data}, set cnt = WIDTH, go to SHIFT.
- SHIFT, once per cycle:
  - Every 4-bit bcd digit ≥ 5 gets +3.
  - Then shift the whole {bcd, bin} register left by 1.
  - cnt decrements.
  - On the shift where cnt reaches 0: copy the bcd field to the out_bcd register and go to DONE.
- DONE:
  - out_valid = 1.
  - On out_valid & out_ready: go to IDLE.
- in_ready is low in SHIFT and DONE. No new operand is accepted until the result has been handed off.
- out_bcd is a dedicated register. It changes only on entry to DONE and holds the last result through IDLE and SHIFT.
- Arithmetic:
  - The digit correction is 4-bit add with no carry out. A digit ≥ 5 is at most 9 before correction, so the sum is ≤ 12.
  - Every digit in out_bcd is in the range 0–9.
- In IDLE, in_data is ignored when in_valid is low.
- Reset:
  - rst high in any state, including mid-SHIFT or in DONE with out_ready low, forces IDLE, clears cnt, the working register and out_bcd, and clears out_valid.
  - A conversion in progress is discarded and no output is produced for it.

## Timing
- Reset values: out_valid = 0, out_bcd = 0, in_ready = 0 while rst is high, in_ready = 1 in the first cycle after rst falls.
- Latency: input accepted at edge N; out_valid is high after edge N + WIDTH (default: 8 cycles).
- Back-to-back throughput with out_ready held high: one conversion per WIDTH + 2 cycles.
- out_valid and out_bcd stay stable while out_ready is low, for any duration.
- A simultaneous out handshake and in_valid in DONE: the output completes; the input is not accepted, because in_ready = 0. It is accepted the next cycle in IDLE.

## Configuration
- Macro: BIN2BCD_2BIT_EN.
- Defined:
  - Each SHIFT cycle performs two cascaded correct-then-shift steps.
  - cnt loads WIDTH/2.
  - Latency is WIDTH/2 cycles (default 4).
  - WIDTH must be even.
- Undefined: one step per cycle, latency WIDTH cycles.
- Results are bit-identical in both builds.

## Test plan
- Reset, then in_data = 0 -> out_bcd = 12'h000, out_valid exactly 8 cycles after accept (4 cycles with BIN2BCD_2BIT_EN).
- in_data = 255, then 99, then 100, then 9, with out_ready = 1 -> out_bcd = 12'h255, 12'h099, 12'h100, 12'h009; successive accepts 10 cycles apart.
- in_data = 173, out_ready held low for 20 cycles -> out_valid and out_bcd = 12'h173 stable throughout; in_ready = 0 throughout; release -> IDLE next cycle.
- Assert rst 3 cycles after accepting 200 -> out_valid = 0 and out_bcd = 0 the next cycle, in_ready = 1 after rst falls; a following in_data = 42 gives 12'h042.
- Exhaustive sweep 0–255 with random in_valid/out_ready gaps -> every result matches the decimal model, every digit ≤ 9, no input dropped or duplicated.
- Hold in_valid high through DONE with a same-cycle out handshake -> the new operand is accepted exactly one cycle later, in IDLE.
